// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word input with a one-entry hold register,
// frames are start, WIDTH data bits LSB first, parity, stop.
module uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] TX_data_in,
  input  logic             TX_valid,
  output logic             TX_ready,
  output logic             TX_data,
  output logic             TX_busy,
  output logic             TX_done,
  output logic [2:0]       state_dbg
);

  // Handshake: a word is taken on any rising edge where TX_valid && TX_ready;
  // the source keeps TX_data_in stable while TX_valid is high and not ready.

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic              ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WIDTH-1:0]  shifter;
  logic [WIDTH-1:0]  hold;
  logic              hold_full;
  logic              parity_bit;

  logic             accept;
  logic             bit_end;
  logic             frame_end;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] next_shift;

  always_comb begin
    accept     = TX_valid && TX_ready;
    bit_end    = (baud_cnt == BAUD_LAST);
    frame_end  = (state == STOP) && bit_end;
    // At frame end a held word takes priority over a newly offered one.
    load_word  = hold_full ? hold : TX_data_in;
    next_shift = shifter >> 1;
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      parity_bit <= 1'b0;
      TX_ready   <= 1'b1;
      TX_data    <= 1'b1;
      TX_busy    <= 1'b0;
      TX_done    <= 1'b0;
    end else begin
      TX_done <= 1'b0;

      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            shifter    <= TX_data_in;
            parity_bit <= (^TX_data_in) ^ ODD;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
            state      <= START;
            TX_data    <= 1'b0;
            TX_busy    <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
            TX_data <= shifter[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
              state   <= PARITY;
              TX_data <= parity_bit;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shifter <= next_shift;
              TX_data <= next_shift[0];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            TX_data <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            TX_done <= 1'b1;
            if (hold_full || TX_valid) begin
              shifter    <= load_word;
              parity_bit <= (^load_word) ^ ODD;
              bit_cnt    <= '0;
              state      <= START;
              TX_data    <= 1'b0;
            end else begin
              state   <= IDLE;
              TX_data <= 1'b1;
              TX_busy <= 1'b0;
            end
            if (hold_full) begin
              hold_full <= 1'b0;
              TX_ready  <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          TX_data <= 1'b1;
          TX_busy <= 1'b0;
        end
      endcase

      // Words arriving mid-frame park in the hold register.
      if (accept && (state != IDLE) && !frame_end) begin
        hold      <= TX_data_in;
        hold_full <= 1'b1;
        TX_ready  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (even/1 clk, odd/1 clk, even/4 clk)
// checked bit by bit against a queue of expected line values.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance a: WIDTH=8, CLKS_PER_BIT=1, even parity
  logic [7:0] a_din = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_data, a_busy, a_done;
  logic [2:0] a_state;
  // Instance o: odd parity
  logic [7:0] o_din = '0;
  logic       o_valid = 1'b0;
  logic       o_ready, o_data, o_busy, o_done;
  logic [2:0] o_state;
  // Instance b: CLKS_PER_BIT=4
  logic [7:0] b_din = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_data, b_busy, b_done;
  logic [2:0] b_state;

  uart_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst(rst), .TX_data_in(a_din), .TX_valid(a_valid),
    .TX_ready(a_ready), .TX_data(a_data), .TX_busy(a_busy), .TX_done(a_done),
    .state_dbg(a_state)
  );
  uart_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_ODD(1)) u_o (
    .clk(clk), .rst(rst), .TX_data_in(o_din), .TX_valid(o_valid),
    .TX_ready(o_ready), .TX_data(o_data), .TX_busy(o_busy), .TX_done(o_done),
    .state_dbg(o_state)
  );
  uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_ODD(0)) u_b (
    .clk(clk), .rst(rst), .TX_data_in(b_din), .TX_valid(b_valid),
    .TX_ready(b_ready), .TX_data(b_data), .TX_busy(b_busy), .TX_done(b_done),
    .state_dbg(b_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];

  // Expected line for one frame: start, data LSB first, parity, stop.
  task automatic push_frame(input logic [7:0] d, input logic odd, input int cpb);
    logic [0:0] bits[11];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9]  = odd;
    for (int i = 0; i < 8; i++) bits[9] = bits[9] ^ d[i];
    bits[10] = 1'b1;
    for (int i = 0; i < 11; i++)
      for (int k = 0; k < cpb; k++) exp_q.push_back(bits[i]);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_data, a_ready, a_busy, a_done} !== 4'b1100) begin
        n_err++;
        $display("FAIL reset_hold: data/ready/busy/done=%b expected 1100", {a_data, a_ready, a_busy, a_done});
      end
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({a_data, a_ready, a_busy, a_done} !== 4'b1100) begin
      n_err++;
      $display("FAIL reset_idle: data/ready/busy/done=%b expected 1100", {a_data, a_ready, a_busy, a_done});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_data, a_ready, a_busy, a_done} !== 4'b1100) begin
        n_err++;
        $display("FAIL reset_release: data/ready/busy/done=%b expected 1100", {a_data, a_ready, a_busy, a_done});
      end
    end
  endtask

  task automatic test_single;
    logic [0:0] e;
    exp_q.delete();
    push_frame(8'hEB, 1'b0, 1);
    @(negedge clk);
    n_cmp++;
    if (a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_ready: got %b expected 1", a_ready);
    end
    a_din = 8'hEB;
    a_valid = 1'b1;
    @(posedge clk);  // accepting edge N
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) begin
        a_valid = 1'b0;
        a_din = $urandom_range(0, 255);  // must not disturb the frame
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL single_line: cycle %0d no expected bit left", c);
      end else begin
        e = exp_q.pop_front();
        if (a_data !== e || a_busy !== 1'b1 || a_done !== 1'b0) begin
          n_err++;
          $display("FAIL single_line: cycle %0d data=%b busy=%b done=%b expected data=%b busy=1 done=0", c, a_data, a_busy, a_done, e);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_data !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: done=%b busy=%b data=%b expected 1 0 1", a_done, a_busy, a_data);
    end
    @(negedge clk);
    n_cmp++;
    if (a_done !== 1'b0) begin
      n_err++;
      $display("FAIL single_done_width: done=%b expected 0", a_done);
    end
  endtask

  task automatic test_back_to_back;
    logic [0:0] e;
    logic exp_ready, exp_done;
    exp_q.delete();
    push_frame(8'h00, 1'b0, 1);
    push_frame(8'hFF, 1'b0, 1);
    @(negedge clk);
    a_din = 8'h00;
    a_valid = 1'b1;
    @(posedge clk);  // edge N: 8'h00 straight to the shifter
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      exp_ready = !(c >= 2 && c <= 11);
      exp_done  = (c == 12 || c == 23);
      n_cmp++;
      if (a_ready !== exp_ready || a_done !== exp_done) begin
        n_err++;
        $display("FAIL b2b_ctrl: cycle %0d ready=%b done=%b expected ready=%b done=%b", c, a_ready, a_done, exp_ready, exp_done);
      end
      n_cmp++;
      if (c <= 22) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_line: cycle %0d no expected bit left", c);
        end else begin
          e = exp_q.pop_front();
          if (a_data !== e || a_busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_line: cycle %0d data=%b busy=%b expected data=%b busy=1", c, a_data, a_busy, e);
          end
        end
      end else if (a_data !== 1'b1 || a_busy !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_idle: data=%b busy=%b expected 1 0", a_data, a_busy);
      end
      if (c == 1) a_din = 8'hFF;  // taken into hold at edge N+1
      if (c == 2) a_valid = 1'b0;
    end
  endtask

  task automatic test_odd_parity;
    logic [0:0] e;
    logic [7:0] words[2];
    words[0] = 8'h01;
    words[1] = 8'h00;
    for (int w = 0; w < 2; w++) begin
      exp_q.delete();
      push_frame(words[w], 1'b1, 1);
      @(negedge clk);
      o_din = words[w];
      o_valid = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 11; c++) begin
        @(negedge clk);
        if (c == 1) o_valid = 1'b0;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL odd_line: word %0d cycle %0d no expected bit left", w, c);
        end else begin
          e = exp_q.pop_front();
          if (o_data !== e) begin
            n_err++;
            $display("FAIL odd_line: word %0d cycle %0d data=%b expected %b", w, c, o_data, e);
          end
        end
      end
      @(negedge clk);
      n_cmp++;
      if (o_done !== 1'b1 || o_busy !== 1'b0) begin
        n_err++;
        $display("FAIL odd_done: word %0d done=%b busy=%b expected 1 0", w, o_done, o_busy);
      end
    end
  endtask

  task automatic test_baud;
    logic [0:0] e;
    int dones;
    exp_q.delete();
    push_frame(8'hA5, 1'b0, 4);
    dones = 0;
    @(negedge clk);
    b_din = 8'hA5;
    b_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      if (c == 1) b_valid = 1'b0;
      if (b_done === 1'b1) dones++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL baud_line: cycle %0d no expected bit left", c);
      end else begin
        e = exp_q.pop_front();
        if (b_data !== e || b_busy !== 1'b1) begin
          n_err++;
          $display("FAIL baud_line: cycle %0d data=%b busy=%b expected data=%b busy=1", c, b_data, b_busy, e);
        end
      end
    end
    for (int c = 45; c <= 50; c++) begin
      @(negedge clk);
      if (b_done === 1'b1) dones++;
      if (c == 45) begin
        n_cmp++;
        if (b_done !== 1'b1 || b_busy !== 1'b0) begin
          n_err++;
          $display("FAIL baud_end: done=%b busy=%b expected 1 0", b_done, b_busy);
        end
      end
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL baud_done_count: got %0d pulses expected 1", dones);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [0:0] e;
    int dones;
    @(negedge clk);
    a_din = 8'h35;  // data bit 3 is 0, so the abort to 1 is visible
    a_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) a_din = 8'hC3;
      if (c == 2) a_valid = 1'b0;
    end
    n_cmp++;
    if (a_data !== 1'b0 || a_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_pre: data=%b ready=%b expected 0 0", a_data, a_ready);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (a_data !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_async: data=%b busy=%b ready=%b expected 1 0 1", a_data, a_busy, a_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (a_done === 1'b1) dones++;
      if (a_data !== 1'b1) begin
        n_cmp++;
        n_err++;
        $display("FAIL abort_quiet: cycle %0d data=%b expected 1", c, a_data);
      end
    end
    n_cmp++;
    if (dones != 0 || a_busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_nodone: pulses=%0d busy=%b expected 0 0", dones, a_busy);
    end
    exp_q.delete();
    push_frame(8'h5A, 1'b0, 1);
    a_din = 8'h5A;
    a_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) a_valid = 1'b0;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL after_abort_line: cycle %0d no expected bit left", c);
      end else begin
        e = exp_q.pop_front();
        if (a_data !== e) begin
          n_err++;
          $display("FAIL after_abort_line: cycle %0d data=%b expected %b", c, a_data, e);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (a_done !== 1'b1) begin
      n_err++;
      $display("FAIL after_abort_done: done=%b expected 1", a_done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_odd_parity();
    test_baud();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that is the upstream partner of the team's UART receiver. Accepts parallel words over a valid/ready handshake, buffers one pending word, and serialises each as start bit, WIDTH data bits (LSB first), one parity bit and one stop bit on a single line. With CLKS_PER_BIT=1 the output drives the receiver's serial input directly, one bit per clock.

## Interface

- WIDTH, 8, data bits per frame (≥1)
- CLKS_PER_BIT, 1, clock cycles each serial bit is held (≥1)
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- TX_data_in  input  WIDTH  parallel word to send
- TX_valid  input  1  TX_data_in is valid
- TX_ready  output  1  block can accept a word this cycle
- TX_data  output  1  serial line, idles high (mark)
- TX_busy  output  1  a frame is being shifted out
- TX_done  output  1  one-cycle pulse after a frame's stop bit completes

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP. TX_busy = (state != IDLE). All outputs are registered.
- Line value per state: IDLE 1, START 0, DATA shifter[0], PARITY computed parity, STOP 1.
- Parity = XOR of the WIDTH data bits, XORed with PARITY_ODD. Computed from the word at load time.
- Counters: baud_cnt 0..CLKS_PER_BIT-1, bit_cnt 0..WIDTH-1. A bit ends when baud_cnt = CLKS_PER_BIT-1. DATA advances bit_cnt and shifts right each bit end. DATA exits after bit_cnt = WIDTH-1.
- Holding register: one entry. TX_ready = !hold_full. Accept when TX_valid && TX_ready.
- Accept while IDLE: the word loads straight into the shifter and the FSM goes to START. The hold register stays empty.
- Accept while busy: the word goes into the hold register, so hold_full=1 and TX_ready=0.
- Frame-end edge is the clock edge at which STOP's last cycle ends. At that edge:
  - If hold_full: load the shifter from hold, go to START, clear hold_full. TX_ready rises.
  - Else if TX_valid (hold empty, so ready): load the accepted word directly and go to START.
  - Otherwise go to IDLE.
- Back-to-back frames therefore have zero idle cycles between stop bit and next start bit.
- TX_data_in is sampled only on the accepting edge. Later changes do not affect a frame in flight.

## Timing

- Reset values: TX_data=1, TX_ready=1, TX_busy=0, TX_done=0. State IDLE, counters 0, hold empty.
- Reset is asynchronous: assertion mid-frame drives TX_data high immediately and aborts the frame. Any held word is discarded. No TX_done is produced for an aborted frame.
- Accept at edge N from IDLE:
  - Start bit appears on TX_data in the cycle after edge N.
  - Frame occupies 11·CLKS_PER_BIT cycles (for WIDTH=8; generally (WIDTH+3)·CLKS_PER_BIT).
  - Frame-end edge is N+(WIDTH+3)·CLKS_PER_BIT.
  - TX_done is high for exactly the cycle following the frame-end edge.
- TX_ready is low from the edge that fills hold until the frame-end edge that drains it.
- A held word therefore waits at most one full frame.
- TX_valid while TX_ready=0 is ignored. The source must hold the word until accepted.

## Test plan

- Reset: assert rst=0 mid-idle, then release. Required: TX_data=1, TX_ready=1, TX_busy=0, TX_done=0 throughout.
- Single word, even parity, CLKS_PER_BIT=1: send 8'hEB accepted at edge N.
  - Required TX_data over cycles N+1..N+11: 0,1,1,0,1,0,1,1,1,0,1.
  - Required TX_done pulse in cycle N+12.
  - Looped into the UART receiver: RX_data_out=8'hEB, parity_bit_err=0, stop_bit_err=0.
- Back-to-back: send 8'h00 then 8'hFF with TX_valid held.
  - Required: 8'hFF is accepted into hold during the first frame, and TX_ready is low until the frame-end edge.
  - Required: the second start bit immediately follows the first stop bit with no gap.
  - Required: parity is 0 in both frames, and there are two TX_done pulses 11 cycles apart.
- Odd parity (PARITY_ODD=1): 8'h01 gives parity bit 0; 8'h00 gives parity bit 1. Stop bit is 1 in both.
- Baud divider (CLKS_PER_BIT=4): send 8'hA5.
  - Required: each line bit is held exactly 4 cycles and the frame lasts 44 cycles.
  - Required: TX_busy is high for those 44 cycles and TX_done pulses once.
- Reset mid-frame: assert rst=0 during data bit 3 with a word in hold.
  - Required: TX_data goes to 1 immediately, with TX_busy=0 and TX_ready=1.
  - Required: no TX_done pulse, and the held word is never transmitted.
  - Required: the next accepted word transmits correctly.
